// File: rtl/line_simplifier_if.sv
`default_nettype none
// ============================================================================
// Module      : line_simplifier_if
// Description : Bundle of line-setup, option-stream and result signals
//               between the solver controller and line_simplifier.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_simplifier_if #(
    parameter int SIZE  = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic [SIZE-1:0]  assigned;
    logic [SIZE-1:0]  known;
    logic             option_valid;
    logic [SIZE-1:0]  option;
    logic             option_last;
    logic             option_ready;
    logic             busy;
    logic             done;
    logic [SIZE-1:0]  new_assigned;
    logic [SIZE-1:0]  new_known;
    logic [CNT_W-1:0] num_valid;
    logic             contradict;
    logic             changed;

    // Controller side: issues the line and the option stream, reads results
    modport master (
        output start, assigned, known, option_valid, option, option_last,
        input  option_ready, busy, done, new_assigned, new_known,
               num_valid, contradict, changed
    );

    // Simplifier side
    modport slave (
        input  start, assigned, known, option_valid, option, option_last,
        output option_ready, busy, done, new_assigned, new_known,
               num_valid, contradict, changed
    );
endinterface
`default_nettype wire

// File: rtl/line_simplifier.sv
`default_nettype none
// ============================================================================
// Module      : line_simplifier
// Description : Streams candidate fills for one nonogram line, discards
//               those contradicting known cells and merges the survivors
//               into a refined assignment / known mask.
// Revision    : 1.0 - initial release
// ============================================================================
module line_simplifier #(
    parameter int SIZE  = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    line_simplifier_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_option_ready;
    logic             w_busy;
    logic             w_done;

    logic [SIZE-1:0]  r_assigned;
    logic [SIZE-1:0]  r_known;
    logic [SIZE-1:0]  r_and_acc;
    logic [SIZE-1:0]  r_or_acc;
    logic [CNT_W-1:0] r_cnt;

    logic [SIZE-1:0]  r_new_assigned;
    logic [SIZE-1:0]  r_new_known;
    logic [CNT_W-1:0] r_num_valid;
    logic             r_contradict;
    logic             r_changed;

    logic             w_start_acc;
    logic             w_beat;
    logic             w_consistent;
    logic             w_take;
    logic             w_finish;
    logic [SIZE-1:0]  w_and_nxt;
    logic [SIZE-1:0]  w_or_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SIZE-1:0]  w_res_known;
    logic [SIZE-1:0]  w_res_assigned;
    logic             w_res_contradict;

    // Handshake qualifiers; a beat only counts while scanning
    assign w_start_acc  = (r_state == S_IDLE) && bus.start;
    assign w_beat       = (r_state == S_SCAN) && bus.option_valid;
    assign w_consistent = (((bus.option ^ r_assigned) & r_known) == '0);
    assign w_take       = w_beat && w_consistent;
    assign w_finish     = w_beat && bus.option_last;

    // Accumulator values including the current beat, so the result can be
    // registered on the same edge that accepts the last option
    assign w_and_nxt = w_take ? (r_and_acc & bus.option) : r_and_acc;
    assign w_or_nxt  = w_take ? (r_or_acc  | bus.option) : r_or_acc;
    assign w_cnt_nxt = (w_take && (r_cnt != c_cnt_max)) ? (r_cnt + CNT_W'(1)) : r_cnt;

    // A saturated counter never wraps to zero, so zero means no survivors
    assign w_res_contradict = (w_cnt_nxt == '0);
    assign w_res_known      = w_res_contradict ? r_known
                                               : (r_known | w_and_nxt | ~w_or_nxt);
    assign w_res_assigned   = w_res_contradict ? (r_assigned & r_known)
                                               : ((r_assigned & r_known) | w_and_nxt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_option_ready = 1'b0;
        w_busy         = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_option_ready = 1'b1;
                w_busy         = 1'b1;
                if (w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line capture and option accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_assigned <= '0;
            r_known    <= '0;
            r_and_acc  <= '1;
            r_or_acc   <= '0;
            r_cnt      <= '0;
        end else if (w_start_acc) begin
            r_assigned <= bus.assigned;
            r_known    <= bus.known;
            r_and_acc  <= '1;
            r_or_acc   <= '0;
            r_cnt      <= '0;
        end else begin
            r_and_acc  <= w_and_nxt;
            r_or_acc   <= w_or_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Result registers, loaded as the pass ends and held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_new_assigned <= '0;
            r_new_known    <= '0;
            r_num_valid    <= '0;
            r_contradict   <= 1'b0;
            r_changed      <= 1'b0;
        end else if (w_finish) begin
            r_new_assigned <= w_res_assigned;
            r_new_known    <= w_res_known;
            r_num_valid    <= w_cnt_nxt;
            r_contradict   <= w_res_contradict;
            r_changed      <= (w_res_known != r_known);
        end
    end

    assign bus.option_ready = w_option_ready;
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign bus.new_assigned = r_new_assigned;
    assign bus.new_known    = r_new_known;
    assign bus.num_valid    = r_num_valid;
    assign bus.contradict   = r_contradict;
    assign bus.changed      = r_changed;

endmodule
`default_nettype wire
